// File: rtl/fp_alu_pkg.sv
// -----------------------------------------------------------------------------
// fp_alu_pkg
// Shared definitions for the floating-point ALU datapath.
//   MANT_W  : default mantissa width
//   SHAMT_W : default alignment shift-amount width
//   grs_t   : guard/round/sticky bundle passed between the aligner,
//             normaliser and rounder
// -----------------------------------------------------------------------------
package fp_alu_pkg;

    localparam int MANT_W  = 16;
    localparam int SHAMT_W = 5;

    typedef struct packed {
        logic guard;
        logic round;
        logic sticky;
    } grs_t;

endpackage

// File: rtl/align_shift_stage.sv
// -----------------------------------------------------------------------------
// align_shift_stage
// Combinational logical right shift of a W-bit vector with sticky collection.
// Every bit pushed out below bit 0 is ORed into sticky_out along with
// sticky_in. Shifts of W or more clear the vector entirely.
// Ports:
//   vec_in     : vector to shift
//   amt        : right-shift amount
//   sticky_in  : sticky accumulated by earlier stages
//   vec_out    : shifted vector
//   sticky_out : sticky_in OR any bit shifted out
// -----------------------------------------------------------------------------
module align_shift_stage #(
    parameter int W     = 18,
    parameter int AMT_W = 5
) (
    input  logic [W-1:0]     vec_in,
    input  logic [AMT_W-1:0] amt,
    input  logic             sticky_in,
    output logic [W-1:0]     vec_out,
    output logic             sticky_out
);

    // Upper half of the double-width shift is the result, the lower half
    // holds exactly the bits that fell off the bottom.
    logic [2*W-1:0] wide;

    always_comb begin
        wide = {vec_in, {W{1'b0}}} >> amt;
        if (int'(amt) >= W) begin
            vec_out    = '0;
            sticky_out = sticky_in | (|vec_in);
        end else begin
            vec_out    = wide[2*W-1:W];
            sticky_out = sticky_in | (|wide[W-1:0]);
        end
    end

endmodule

// File: rtl/mantissa_align_shifter.sv
// -----------------------------------------------------------------------------
// mantissa_align_shifter
// Two-stage elastic right shifter for mantissa alignment. The mantissa is
// extended with two zero bits below the LSB, shifted right, and the bits that
// land below the mantissa become guard, round and sticky.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : input handshake
//   in_data, in_shamt     : mantissa and right-shift amount
//   out_valid/out_ready   : output handshake
//   out_data              : aligned mantissa
//   out_guard/out_round   : first/second bit below the LSB
//   out_sticky            : OR of every bit below the round position
// -----------------------------------------------------------------------------
module mantissa_align_shifter #(
    parameter int WIDTH   = fp_alu_pkg::MANT_W,
    parameter int SHAMT_W = fp_alu_pkg::SHAMT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_guard,
    output logic               out_round,
    output logic               out_sticky
);

    import fp_alu_pkg::*;

    localparam int EXT_W = WIDTH + 2;

    logic               vld_p1;
    logic [EXT_W-1:0]   ext_p1;
    logic               sticky_p1;
    logic [1:0]         fine_p1;

    logic               vld_p2;
    logic [WIDTH-1:0]   data_p2;
    grs_t               grs_p2;

    logic               s2_ready;
    logic [SHAMT_W-1:0] coarse_amt;
    logic [EXT_W-1:0]   ext_s1;
    logic               sticky_s1;
    logic [EXT_W-1:0]   ext_s2;
    logic               sticky_s2;

    // Stage 2 frees up when empty or draining; stage 1 can refill in the
    // same cycle it hands off, so a full pipe streams without bubbles.
    assign s2_ready = !vld_p2 || out_ready;
    assign in_ready = !vld_p1 || s2_ready;

    // Stage 1: coarse shift by the multiple-of-4 part of the amount.
    assign coarse_amt = {in_shamt[SHAMT_W-1:2], 2'b00};

    align_shift_stage #(.W(EXT_W), .AMT_W(SHAMT_W)) u_coarse (
        .vec_in     ({in_data, 2'b00}),
        .amt        (coarse_amt),
        .sticky_in  (1'b0),
        .vec_out    (ext_s1),
        .sticky_out (sticky_s1)
    );

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            ext_p1    <= ext_s1;
            sticky_p1 <= sticky_s1;
            fine_p1   <= in_shamt[1:0];
        end
    end

    // Stage 2: residual shift of 0..3.
    align_shift_stage #(.W(EXT_W), .AMT_W(2)) u_fine (
        .vec_in     (ext_p1),
        .amt        (fine_p1),
        .sticky_in  (sticky_p1),
        .vec_out    (ext_s2),
        .sticky_out (sticky_s2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            data_p2 <= '0;
            grs_p2  <= '0;
        end else begin
            if (in_ready) begin
                vld_p1 <= in_valid;
            end
            if (s2_ready) begin
                vld_p2 <= vld_p1;
            end
            // Output registers only load on advance, so a stalled result
            // holds steady until the consumer takes it.
            if (vld_p1 && s2_ready) begin
                data_p2       <= ext_s2[EXT_W-1:2];
                grs_p2.guard  <= ext_s2[1];
                grs_p2.round  <= ext_s2[0];
                grs_p2.sticky <= sticky_s2;
            end
        end
    end

    assign out_valid  = vld_p2;
    assign out_data   = data_p2;
    assign out_guard  = grs_p2.guard;
    assign out_round  = grs_p2.round;
    assign out_sticky = grs_p2.sticky;

endmodule

// File: tb/tb_mantissa_align_shifter.sv
// -----------------------------------------------------------------------------
// tb_mantissa_align_shifter
// Directed and streaming bench for mantissa_align_shifter. The reference
// model computes the aligned result arithmetically on a 64-bit value; a
// scoreboard queue tracks accepted inputs and every valid output cycle is
// compared against the oldest outstanding expectation.
// -----------------------------------------------------------------------------
module tb_mantissa_align_shifter;

    localparam int WIDTH   = 16;
    localparam int SHAMT_W = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_guard;
    logic               out_round;
    logic               out_sticky;

    int tests = 0;
    int fails = 0;
    int rcv   = 0;

    logic [WIDTH+2:0] q[$];

    logic             s_rst = 1'b0;
    logic             s_in  = 1'b0;
    logic             s_out = 1'b0;
    logic [WIDTH+2:0] s_exp = '0;

    bit stop_rand;

    mantissa_align_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_shamt   (in_shamt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_guard  (out_guard),
        .out_round  (out_round),
        .out_sticky (out_sticky)
    );

    always #5 clk = ~clk;

    // Result packed as {data, guard, round, sticky}.
    function automatic logic [WIDTH+2:0] ref_shift(input logic [WIDTH-1:0] d,
                                                   input logic [SHAMT_W-1:0] sh);
        logic [63:0] ext, kept, lost;
        ext  = 64'(d) << 2;
        kept = ext >> sh;
        lost = ext & ((64'd1 << sh) - 64'd1);
        return {kept[WIDTH+1:0], lost != 64'd0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sample handshakes mid-cycle when everything is settled; compare outputs.
    always @(negedge clk) begin
        s_rst = rst;
        s_in  = in_valid && in_ready;
        s_out = out_valid && out_ready;
        s_exp = ref_shift(in_data, in_shamt);
        if (!rst && out_valid) begin
            if (q.size() == 0)
                check("spurious_out_valid", 32'(out_valid), 32'd0);
            else
                check("out_vs_model", 32'({out_data, out_guard, out_round, out_sticky}), 32'(q[0]));
        end
    end

    always @(posedge clk) begin
        if (s_rst) begin
            q.delete();
        end else begin
            if (s_out && q.size() > 0) begin
                void'(q.pop_front());
                rcv++;
            end
            if (s_in) q.push_back(s_exp);
        end
    end

    task automatic drive(input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] sh);
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = sh;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) check("accept_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 1000; k++) begin
            if (q.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    // Presented in one cycle, result visible two cycles later.
    task automatic directed(input string name, input logic [WIDTH-1:0] d,
                            input logic [SHAMT_W-1:0] sh, input logic [WIDTH+2:0] exp);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = sh;
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({name, "_lat1"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check(name, 32'({out_data, out_guard, out_round, out_sticky}), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [WIDTH-1:0]   bp_d[4];
        logic [SHAMT_W-1:0] bp_s[4];

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        out_ready = 1'b1;

        // Pin the model with hand-derived values.
        check("model_8001_3",  32'(ref_shift(16'h8001, 5'd3)),  32'({16'h1000, 3'b001}));
        check("model_C000_17", 32'(ref_shift(16'hC000, 5'd17)), 32'({16'h0000, 3'b011}));
        check("model_FFFF_4",  32'(ref_shift(16'hFFFF, 5'd4)),  32'({16'h0FFF, 3'b111}));

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_grs",       32'({out_guard, out_round, out_sticky}), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        directed("d_8001_3",  16'h8001, 5'd3,  {16'h1000, 3'b001});
        directed("d_0003_1",  16'h0003, 5'd1,  {16'h0001, 3'b100});
        directed("d_ABCD_0",  16'hABCD, 5'd0,  {16'hABCD, 3'b000});
        directed("d_C000_17", 16'hC000, 5'd17, {16'h0000, 3'b011});
        directed("d_0001_31", 16'h0001, 5'd31, {16'h0000, 3'b001});
        directed("d_0000_20", 16'h0000, 5'd20, {16'h0000, 3'b000});
        directed("d_FFFF_18", 16'hFFFF, 5'd18, {16'h0000, 3'b001});
        directed("d_0003_2",  16'h0003, 5'd2,  {16'h0000, 3'b110});
        directed("d_8000_16", 16'h8000, 5'd16, {16'h0000, 3'b100});
        directed("d_FFFF_4",  16'hFFFF, 5'd4,  {16'h0FFF, 3'b111});
        drain();

        // Backpressure: four back-to-back inputs against a stalled consumer.
        bp_d = '{16'h1234, 16'h8001, 16'hFFFF, 16'h00F0};
        bp_s = '{5'd0, 5'd5, 5'd9, 5'd2};
        base = rcv;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) drive(bp_d[i], bp_s[i]);
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #2;
                check("bp_in_ready_low", 32'(in_ready), 32'd0);
                check("bp_out_valid",    32'(out_valid), 32'd1);
                repeat (4) @(posedge clk);
                #2;
                check("bp_still_stalled", 32'(rcv - base), 32'd0);
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", 32'(rcv - base), 32'd4);

        // Streaming with random backpressure.
        base = rcv;
        stop_rand = 1'b0;
        fork
            begin
                for (int i = 0; i < 100; i++)
                    drive(16'($urandom), 5'($urandom_range(0, 31)));
                stop_rand = 1'b1;
            end
            begin
                while (!stop_rand) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();
        check("stream_count", 32'(rcv - base), 32'd100);

        // Reset with both stages full.
        base = rcv;
        out_ready = 1'b0;
        drive(16'hAAAA, 5'd1);
        drive(16'h5555, 5'd7);
        check("rf_full_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rf_out_valid", 32'(out_valid), 32'd0);
        check("rf_out_data",  32'(out_data),  32'd0);
        check("rf_in_ready",  32'(in_ready),  32'd1);
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("rf_no_stale", 32'(rcv - base), 32'd0);
        directed("rf_after", 16'h0100, 5'd8, {16'h0001, 3'b000});
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
